// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared constants for the GPIO/IRQ controller: register word indices,
// default parameter values and the debouncer state encoding.
package gpio_irq_ctrl_pkg;

  localparam int G_NUM_IN_DEF      = 16;
  localparam int G_NUM_OUT_DEF     = 16;
  localparam int G_DB_W_DEF        = 20;
  localparam int G_SYNC_STAGES_DEF = 2;
  localparam int G_ADDR_W_DEF      = 6;

  localparam int G_DIN_IONUM      = 0;
  localparam int G_DOUT_IONUM     = 1;
  localparam int G_DOUT_SET_IONUM = 2;
  localparam int G_DOUT_CLR_IONUM = 3;
  localparam int G_DOUT_TGL_IONUM = 4;
  localparam int G_IRQ_EN_IONUM   = 5;
  localparam int G_IRQ_RISE_IONUM = 6;
  localparam int G_IRQ_FALL_IONUM = 7;
  localparam int G_IRQ_PEND_IONUM = 8;
  localparam int G_DEBOUNCE_IONUM = 9;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: synchroniser chain followed by a saturating-counter
// debouncer that commits a new level once it has held for threshold+1 cycles.
module gpio_debounce
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int DB_W        = G_DB_W_DEF,
  parameter int SYNC_STAGES = G_SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            pin,
  input  logic [DB_W-1:0] threshold,
  output logic            stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_e              state_q, state_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q   <= '0;
      state_q  <= DB_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // >= rather than == so a threshold lowered below the running count commits next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    unique case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (sync != stable_q) begin
          if (threshold == '0) begin
            stable_d = sync;
          end else begin
            cnt_d   = DB_W'(1);
            state_d = DB_COUNTING;
          end
        end
      end
      DB_COUNTING: begin
        if (sync == stable_q) begin
          cnt_d   = '0;
          state_d = DB_STABLE;
        end else if (cnt_q >= threshold) begin
          stable_d = sync;
          cnt_d    = '0;
          state_d  = DB_STABLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO block: debounced inputs, atomic output writes and
// per-channel edge interrupts with sticky pending bits and an enable mask.
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int NUM_IN      = G_NUM_IN_DEF,
  parameter int NUM_OUT     = G_NUM_OUT_DEF,
  parameter int DB_W        = G_DB_W_DEF,
  parameter int SYNC_STAGES = G_SYNC_STAGES_DEF,
  parameter int ADDR_W      = G_ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic                we,
  input  logic [31:0]         datain,
  output logic [31:0]         dataout,
  output logic                dataout_ready,
  input  logic [NUM_IN-1:0]   gpio_in,
  output logic [NUM_OUT-1:0]  gpio_out
  , output logic              irq
);

  logic                sel_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_OUT-1:0]  dout_q, dout_d;
  logic [NUM_IN-1:0]   en_q, en_d;
  logic [NUM_IN-1:0]   rise_q, rise_d;
  logic [NUM_IN-1:0]   fall_q, fall_d;
  logic [NUM_IN-1:0]   pend_q, pend_d;
  logic [NUM_IN-1:0]   stable, stable_prev_q;
  logic [NUM_IN-1:0]   w1c, evt;
  logic [DB_W-1:0]     thr_q, thr_d;
  logic                irq_q, irq_d;
  logic                wr;
  logic                unused_datain;

  assign unused_datain = ^datain;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    gpio_debounce #(
      .DB_W        (DB_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .clk       (clk),
      .clr       (clr),
      .pin       (gpio_in[g]),
      .threshold (thr_q),
      .stable    (stable[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
      en_q          <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      pend_q        <= '0;
      thr_q         <= '0;
      stable_prev_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      sel_q         <= HSEL;
      we_q          <= we;
      addr_q        <= haddr;
      dout_q        <= dout_d;
      en_q          <= en_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      pend_q        <= pend_d;
      thr_q         <= thr_d;
      stable_prev_q <= stable;
      irq_q         <= irq_d;
    end
  end

  // Address phase is registered; datain is consumed in the following cycle.
  assign wr = sel_q & we_q;

  always_comb begin
    dout_d = dout_q;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    thr_d  = thr_q;
    w1c    = '0;
    if (wr) begin
      case (int'(addr_q))
        G_DOUT_IONUM:     dout_d = datain[NUM_OUT-1:0];
        G_DOUT_SET_IONUM: dout_d = dout_q | datain[NUM_OUT-1:0];
        G_DOUT_CLR_IONUM: dout_d = dout_q & ~datain[NUM_OUT-1:0];
        G_DOUT_TGL_IONUM: dout_d = dout_q ^ datain[NUM_OUT-1:0];
        G_IRQ_EN_IONUM:   en_d   = datain[NUM_IN-1:0];
        G_IRQ_RISE_IONUM: rise_d = datain[NUM_IN-1:0];
        G_IRQ_FALL_IONUM: fall_d = datain[NUM_IN-1:0];
        G_IRQ_PEND_IONUM: w1c    = datain[NUM_IN-1:0];
        G_DEBOUNCE_IONUM: thr_d  = datain[DB_W-1:0];
        default: ;
      endcase
    end
  end

  assign evt    = (stable & ~stable_prev_q & rise_q) | (~stable & stable_prev_q & fall_q);
  assign pend_d = (pend_q & ~w1c) | evt;
  assign irq_d  = |(pend_d & en_d);

  always_comb begin
    dataout = '0;
    if (HSEL) begin
      case (int'(haddr))
        G_DIN_IONUM:      dataout = 32'(stable);
        G_DOUT_IONUM:     dataout = 32'(dout_q);
        G_IRQ_EN_IONUM:   dataout = 32'(en_q);
        G_IRQ_RISE_IONUM: dataout = 32'(rise_q);
        G_IRQ_FALL_IONUM: dataout = 32'(fall_q);
        G_IRQ_PEND_IONUM: dataout = 32'(pend_q);
        G_DEBOUNCE_IONUM: dataout = 32'(thr_q);
        default:          dataout = '0;
      endcase
    end
  end

  assign dataout_ready = sel_q;
  assign gpio_out      = dout_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed-vector bench for gpio_irq_ctrl with hand-computed expectations.
module tb_gpio_irq_ctrl;
  import gpio_irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        HSEL;
  logic [5:0]  haddr;
  logic        we;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        dataout_ready;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(
    .NUM_IN      (16),
    .NUM_OUT     (16),
    .DB_W        (20),
    .SYNC_STAGES (2),
    .ADDR_W      (6)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .HSEL          (HSEL),
    .haddr         (haddr),
    .we            (we),
    .datain        (datain),
    .dataout       (dataout),
    .dataout_ready (dataout_ready),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .irq           (irq)
  );

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk); HSEL = 1'b1; we = 1'b1; haddr = a; datain = '0;
    @(negedge clk); HSEL = 1'b0; we = 1'b0; datain = d;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk); HSEL = 1'b1; we = 1'b0; haddr = a;
    #1 d = dataout;
    @(negedge clk); HSEL = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    clr = 1'b1; HSEL = 1'b0; we = 1'b0; haddr = '0; datain = '0; gpio_in = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (gpio_out !== 16'h0) begin miscompares++; $display("FAIL rst_gpio_out got=%h exp=0000", gpio_out); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got=%b exp=0", irq); end
    vectors++; if (dataout_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b exp=0", dataout_ready); end
    @(negedge clk); clr = 1'b0;
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rst_pend got=%h exp=0", r); end
    bus_read(6'(G_DIN_IONUM), r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rst_din got=%h exp=0", r); end
  endtask

  task automatic test_outputs();
    logic [31:0] r;
    bus_write(6'(G_DOUT_IONUM), 32'hABCD_1234);
    bus_read(6'(G_DOUT_IONUM), r);
    vectors++; if (r !== 32'h0000_1234) begin miscompares++; $display("FAIL dout_hi_bits got=%h exp=00001234", r); end
    bus_read(6'(G_DOUT_SET_IONUM), r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL set_reads_zero got=%h exp=0", r); end
    bus_read(6'd12, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL undef_reads_zero got=%h exp=0", r); end

    bus_write(6'(G_DOUT_IONUM), 32'h0000_00F0);
    vectors++; if (gpio_out !== 16'h00F0) begin miscompares++; $display("FAIL dout_wr got=%h exp=00f0", gpio_out); end
    bus_read(6'(G_DOUT_IONUM), r);
    vectors++; if (r !== 32'h0000_00F0) begin miscompares++; $display("FAIL dout_rd got=%h exp=000000f0", r); end
    bus_write(6'(G_DOUT_SET_IONUM), 32'h0000_000F);
    bus_read(6'(G_DOUT_IONUM), r);
    vectors++; if (r !== 32'h0000_00FF) begin miscompares++; $display("FAIL dout_set got=%h exp=000000ff", r); end
    bus_write(6'(G_DOUT_CLR_IONUM), 32'h0000_0030);
    bus_read(6'(G_DOUT_IONUM), r);
    vectors++; if (r !== 32'h0000_00CF) begin miscompares++; $display("FAIL dout_clr got=%h exp=000000cf", r); end
    bus_write(6'(G_DOUT_TGL_IONUM), 32'h0000_0101);
    bus_read(6'(G_DOUT_IONUM), r);
    vectors++; if (r !== 32'h0000_01CE) begin miscompares++; $display("FAIL dout_tgl got=%h exp=000001ce", r); end
    vectors++; if (gpio_out !== 16'h01CE) begin miscompares++; $display("FAIL gpio_out_final got=%h exp=01ce", gpio_out); end
  endtask

  task automatic test_bus_timing();
    @(negedge clk); HSEL = 1'b0; haddr = 6'(G_DOUT_IONUM);
    @(negedge clk); #1;
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL unsel_dataout got=%h exp=0", dataout); end
    vectors++; if (dataout_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got=%b exp=0", dataout_ready); end
    HSEL = 1'b1; #1;
    vectors++; if (dataout !== 32'h0000_01CE) begin miscompares++; $display("FAIL comb_read got=%h exp=000001ce", dataout); end
    vectors++; if (dataout_ready !== 1'b0) begin miscompares++; $display("FAIL ready_early got=%b exp=0", dataout_ready); end
    @(posedge clk); #1;
    vectors++; if (dataout_ready !== 1'b1) begin miscompares++; $display("FAIL ready_set got=%b exp=1", dataout_ready); end
    @(negedge clk); HSEL = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dataout_ready !== 1'b0) begin miscompares++; $display("FAIL ready_drop got=%b exp=0", dataout_ready); end
  endtask

  task automatic test_debounce();
    logic [31:0] r;
    logic seen;
    bus_write(6'(G_DEBOUNCE_IONUM), 32'hFFFF_FFFF);
    bus_read(6'(G_DEBOUNCE_IONUM), r);
    vectors++; if (r !== 32'h000F_FFFF) begin miscompares++; $display("FAIL db_width got=%h exp=000fffff", r); end
    bus_write(6'(G_DEBOUNCE_IONUM), 32'd4);

    @(negedge clk); HSEL = 1'b1; we = 1'b0; haddr = 6'(G_DIN_IONUM);
    gpio_in[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 2) gpio_in[0] = 1'b0;
      seen = seen | dataout[0];
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL glitch_filtered got=%b exp=0", seen); end

    gpio_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (dataout[0] !== (k >= 7)) begin
        miscompares++;
        $display("FAIL db_latency cyc=%0d got=%b exp=%b", k, dataout[0], (k >= 7));
      end
    end
    gpio_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (dataout[0] !== 1'b0) begin miscompares++; $display("FAIL db_release got=%b exp=0", dataout[0]); end
    HSEL = 1'b0;
  endtask

  task automatic test_rise_irq();
    logic [31:0] r;
    bus_write(6'(G_IRQ_RISE_IONUM), 32'h1);
    bus_write(6'(G_IRQ_EN_IONUM), 32'h1);
    bus_write(6'(G_DEBOUNCE_IONUM), 32'h0);
    @(negedge clk); gpio_in[0] = 1'b1;
    repeat (2) @(negedge clk); gpio_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rise_irq got=%b exp=1", irq); end
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h1) begin miscompares++; $display("FAIL rise_pend got=%h exp=1", r); end
    bus_write(6'(G_IRQ_PEND_IONUM), 32'h1);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got=%b exp=0", irq); end
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL w1c_pend got=%h exp=0", r); end
  endtask

  task automatic test_fall_mask();
    logic [31:0] r;
    bus_write(6'(G_IRQ_EN_IONUM), 32'h0);
    bus_write(6'(G_IRQ_FALL_IONUM), 32'h2);
    @(negedge clk); gpio_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL fall_no_rise got=%h exp=0", r); end
    @(negedge clk); gpio_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL fall_pend got=%h exp=2", r); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL fall_masked got=%b exp=0", irq); end
    bus_write(6'(G_IRQ_EN_IONUM), 32'h2);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL fall_enable got=%b exp=1", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] r;
    bus_write(6'(G_IRQ_PEND_IONUM), 32'h2);
    bus_write(6'(G_IRQ_EN_IONUM), 32'h1);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL coll_pre_irq got=%b exp=0", irq); end
    @(negedge clk); gpio_in[0] = 1'b1;
    repeat (2) @(negedge clk); gpio_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL coll_setup_irq got=%b exp=1", irq); end
    // New rising edge timed so its pend-set lands on the W1C commit edge.
    gpio_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); HSEL = 1'b1; we = 1'b1; haddr = 6'(G_IRQ_PEND_IONUM);
    @(negedge clk); HSEL = 1'b0; we = 1'b0; datain = 32'h1;
    @(posedge clk); #1;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL coll_irq got=%b exp=1", irq); end
    bus_read(6'(G_IRQ_PEND_IONUM), r);
    vectors++; if (r !== 32'h1) begin miscompares++; $display("FAIL coll_pend got=%h exp=1", r); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL coll_irq_hold got=%b exp=1", irq); end
    gpio_in[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_outputs();
    test_bus_timing();
    test_debounce();
    test_rise_irq();
    test_fall_mask();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
